// File: rtl/router_arbiter_rr.sv
// router_arbiter_rr: registered N-way packet-holding arbiter, fixed-priority or round-robin.
// Define ARB_HOLD_TIMEOUT_EN to let a holder be preempted after HOLD_MAX grant cycles.
module router_arbiter_rr #(
    parameter int N_REQ    = 16,
    parameter int RR_MODE  = 1,
    parameter int HOLD_MAX = 64,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             preempt
);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] own, last, start, win;
    logic [N_REQ-1:0] own_bit, cand;
    logic take, timeout;

    if (N_REQ < 2 || N_REQ > 64 || HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_bad_param
        $error("router_arbiter_rr: parameter out of range");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            own   <= '0;
            last  <= IDX_W'(N_REQ - 1);
        end else begin
            state <= state_n;
            if (take) begin
                own  <= win;
                last <= win;
            end
        end
    end

    always_comb begin
        own_bit      = '0;
        own_bit[own] = 1'b1;
    end

    // Round-robin search begins just after the last winner; fixed priority always from 0.
    assign start = (RR_MODE != 0 && last != IDX_W'(N_REQ - 1)) ? last + 1'b1 : '0;

    always_comb begin
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (cand[(int'(start) + k) % N_REQ]) win = IDX_W'((int'(start) + k) % N_REQ);
    end

    // A release by the owner takes precedence over a coincident timeout.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        cand    = request;
        if (state == IDLE || !request[own]) begin
            take    = |request;
            state_n = take ? OWNED : IDLE;
        end else if (timeout) begin
            take = 1'b1;
            cand = request & ~own_bit;
        end
    end

    always_comb begin
        busy      = state == OWNED;
        grant     = busy ? own_bit : '0;
        grant_idx = own;
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] hold;
    logic          pre_q;
    assign timeout = hold >= CW'(HOLD_MAX - 1) && |(request & ~own_bit);
    always_ff @(posedge clk) begin
        if (reset || take) hold <= '0;
        else if (state == OWNED && hold != CW'(HOLD_MAX)) hold <= hold + 1'b1;
        pre_q <= !reset && state == OWNED && request[own] && timeout;
    end
    assign preempt = pre_q;
`else
    assign timeout = 1'b0;
    assign preempt = 1'b0;
`endif
endmodule

// File: tb/tb_router_arbiter_rr.sv
// tb_router_arbiter_rr: directed scenarios plus randomized traffic against a queue-free reference model.
module tb_router_arbiter_rr;
    localparam int HM = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic [15:0] request = 16'hFFFF;
    logic [15:0] g_fp, g_rr;
    logic [3:0]  gi_fp, gi_rr;
    logic        b_fp, b_rr, p_fp, p_rr;
    int checks = 0, errors = 0;
    int m_own[2], m_last[2], m_idx[2], m_cyc[2];
    bit m_pre[2];

    always #5 clk = ~clk;

    router_arbiter_rr #(.N_REQ(16), .RR_MODE(0), .HOLD_MAX(HM)) dut_fp (
        .clk(clk), .reset(reset), .request(request),
        .grant(g_fp), .grant_idx(gi_fp), .busy(b_fp), .preempt(p_fp));
    router_arbiter_rr #(.N_REQ(16), .RR_MODE(1), .HOLD_MAX(HM)) dut_rr (
        .clk(clk), .reset(reset), .request(request),
        .grant(g_rr), .grant_idx(gi_rr), .busy(b_rr), .preempt(p_rr));

    // Winner per the arbitration rule: rr scans last+1, last+2, ... with wrap; fixed scans 0 upward.
    function automatic int pick(input bit rr, input int last, input logic [15:0] r);
        for (int i = 0; i < 16; i++) begin
            int p;
            p = rr ? (last + 1 + i) % 16 : i;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    // m_own = -1 when idle; m_cyc = number of cycles the current owner has held the grant.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_own[m] <= -1; m_last[m] <= 15; m_idx[m] <= 0; m_cyc[m] <= 0; m_pre[m] <= 1'b0;
            end else if (m_own[m] < 0 || !request[m_own[m]]) begin
                m_own[m] <= pick(m == 1, m_last[m], request);
                m_pre[m] <= 1'b0;
                if (request != 16'h0) begin
                    m_last[m] <= pick(m == 1, m_last[m], request);
                    m_idx[m]  <= pick(m == 1, m_last[m], request);
                    m_cyc[m]  <= 1;
                end
            end else if (TO_EN && m_cyc[m] >= HM && (request & ~(16'd1 << m_own[m])) != 16'h0) begin
                m_own[m]  <= pick(m == 1, m_last[m], request & ~(16'd1 << m_own[m]));
                m_last[m] <= pick(m == 1, m_last[m], request & ~(16'd1 << m_own[m]));
                m_idx[m]  <= pick(m == 1, m_last[m], request & ~(16'd1 << m_own[m]));
                m_cyc[m]  <= 1;
                m_pre[m]  <= 1'b1;
            end else begin
                m_cyc[m] <= m_cyc[m] + 1;
                m_pre[m] <= 1'b0;
            end
        end
    end

    task automatic step(input logic [15:0] r);
        request = r;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        request = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({g_fp, g_rr, b_fp, b_rr, p_fp, p_rr} !== 36'h0) begin
                errors++;
                $display("FAIL reset_hold: grant fp=%h rr=%h busy=%b%b preempt=%b%b, required all zero",
                         g_fp, g_rr, b_fp, b_rr, p_fp, p_rr);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({g_fp, gi_fp, b_fp} !== {16'h0001, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release_fp: grant=%h idx=%0d busy=%b, required 0001/0/1", g_fp, gi_fp, b_fp);
        end
        checks++;
        if ({g_rr, gi_rr, b_rr} !== {16'h0001, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release_rr: grant=%h idx=%0d busy=%b, required 0001/0/1", g_rr, gi_rr, b_rr);
        end
    endtask

    task automatic test_fixed;
        step(16'h0000);
        checks++;
        if ({g_fp, b_fp} !== 17'h0) begin
            errors++;
            $display("FAIL fixed_idle: grant=%h busy=%b, required 0000/0", g_fp, b_fp);
        end
        step(16'h0A00);
        checks++;
        if (g_fp !== 16'h0200) begin
            errors++;
            $display("FAIL fixed_first: grant=%h, required 0200", g_fp);
        end
        step(16'h0A02);
        checks++;
        if (g_fp !== 16'h0200) begin
            errors++;
            $display("FAIL fixed_hold: grant=%h, required 0200", g_fp);
        end
        step(16'h0002);
        checks++;
        if ({g_fp, gi_fp} !== {16'h0002, 4'd1}) begin
            errors++;
            $display("FAIL fixed_release: grant=%h idx=%0d, required 0002/1", g_fp, gi_fp);
        end
        step(16'h0000);
    endtask

    task automatic test_rr;
        logic [15:0] reqs [7] = '{16'h8011, 16'h8010, 16'h8011, 16'h8001, 16'h8011, 16'h0011, 16'h0000};
        logic [15:0] exps [7] = '{16'h0001, 16'h0010, 16'h0010, 16'h8000, 16'h8000, 16'h0001, 16'h0000};
        reset = 1'b1;
        step(16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(reqs[i]);
            checks++;
            if ({g_rr, b_rr} !== {exps[i], exps[i] != 16'h0}) begin
                errors++;
                $display("FAIL rr_rotate[%0d]: grant=%h busy=%b, required %h", i, g_rr, b_rr, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        step(16'h0008);
        step(16'h0088);
        checks++;
        if ({g_fp, g_rr} !== {16'h0008, 16'h0008}) begin
            errors++;
            $display("FAIL b2b_owner: grant fp=%h rr=%h, required 0008", g_fp, g_rr);
        end
        step(16'h0080);
        checks++;
        if ({g_fp, g_rr, b_fp, b_rr} !== {16'h0080, 16'h0080, 2'b11}) begin
            errors++;
            $display("FAIL b2b_handoff: grant fp=%h rr=%h busy=%b%b, required 0080/11", g_fp, g_rr, b_fp, b_rr);
        end
        step(16'h0000);
    endtask

    task automatic test_timeout;
        logic [15:0] eg;
        step(16'h0024);
        for (int i = 0; i < 3; i++) begin
            step(16'h0024);
            checks++;
            if ({g_fp, g_rr, p_fp, p_rr} !== {16'h0004, 16'h0004, 2'b00}) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: grant fp=%h rr=%h preempt=%b%b, required 0004/00",
                         i, g_fp, g_rr, p_fp, p_rr);
            end
        end
        eg = TO_EN ? 16'h0020 : 16'h0004;
        step(16'h0024);
        checks++;
        if ({g_fp, g_rr, p_fp, p_rr} !== {eg, eg, TO_EN, TO_EN}) begin
            errors++;
            $display("FAIL timeout_fire: grant fp=%h rr=%h preempt=%b%b, required %h/%b",
                     g_fp, g_rr, p_fp, p_rr, eg, TO_EN);
        end
        step(16'h0024);
        checks++;
        if ({g_fp, g_rr, p_fp, p_rr} !== {eg, eg, 2'b00}) begin
            errors++;
            $display("FAIL timeout_pulse: grant fp=%h rr=%h preempt=%b%b, required %h/00", g_fp, g_rr, p_fp, p_rr, eg);
        end
        step(16'h0000);
        step(16'h0004);
        for (int i = 0; i < 7; i++) begin
            step(16'h0004);
            checks++;
            if ({g_fp, g_rr, p_fp, p_rr} !== {16'h0004, 16'h0004, 2'b00}) begin
                errors++;
                $display("FAIL timeout_sole[%0d]: grant fp=%h rr=%h preempt=%b%b, required 0004/00",
                         i, g_fp, g_rr, p_fp, p_rr);
            end
        end
        step(16'h0024);
        checks++;
        if ({g_fp, g_rr, p_fp, p_rr} !== {eg, eg, TO_EN, TO_EN}) begin
            errors++;
            $display("FAIL timeout_saturated: grant fp=%h rr=%h preempt=%b%b, required %h/%b",
                     g_fp, g_rr, p_fp, p_rr, eg, TO_EN);
        end
        step(16'h0000);
    endtask

    task automatic test_reset_mid;
        step(16'h0040);
        checks++;
        if ({g_fp, g_rr} !== {16'h0040, 16'h0040}) begin
            errors++;
            $display("FAIL midreset_grant: grant fp=%h rr=%h, required 0040", g_fp, g_rr);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({g_fp, g_rr, b_fp, b_rr} !== 34'h0) begin
            errors++;
            $display("FAIL midreset_drop: grant fp=%h rr=%h busy=%b%b, required 0", g_fp, g_rr, b_fp, b_rr);
        end
        reset = 1'b0;
        step(16'h8041);
        checks++;
        if ({g_rr, gi_rr} !== {16'h0001, 4'd0}) begin
            errors++;
            $display("FAIL midreset_rr_restart: grant=%h idx=%0d, required 0001/0", g_rr, gi_rr);
        end
        step(16'h0000);
    endtask

    task automatic test_random;
        reset = 1'b1;
        step(16'h0000);
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) request = 16'($urandom) & 16'($urandom);
            reset = $urandom_range(0, 79) == 0;
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                logic [15:0] eg;
                logic [21:0] act;
                eg  = m_own[m] >= 0 ? 16'd1 << m_own[m] : 16'h0;
                act = m == 1 ? {g_rr, gi_rr, b_rr, p_rr} : {g_fp, gi_fp, b_fp, p_fp};
                checks++;
                if (act !== {eg, 4'(m_idx[m]), m_own[m] >= 0, m_pre[m]}) begin
                    errors++;
                    $display("FAIL random_%s[%0d]: req=%h grant/idx/busy/pre=%h/%0d/%b/%b, required %h/%0d/%b/%b",
                             m == 1 ? "rr" : "fp", c, request, act[21:6], act[5:2], act[1], act[0],
                             eg, m_idx[m], m_own[m] >= 0, m_pre[m]);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_fixed;
        test_rr;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_arbiter_rr.md
# router_arbiter_rr

Parametrised, registered N-way arbiter for router output ports. It selects one input port at a time and holds that grant while the winner keeps requesting, so a packet is never interleaved. Arbitration is fixed-priority or round-robin, chosen by parameter, and an optional hold-timeout can preempt a long holder. One instance sits in front of each output port's crossbar select, replacing the fixed 16-way combinational arbiter.

## Interface
- `N_REQ`, 16: number of requesters; legal values are 2 to 64.
- `RR_MODE`, 1: 1 selects round-robin, 0 selects fixed priority (index 0 highest).
- `HOLD_MAX`, 64: maximum grant cycles before preemption; legal range 1 to 65535; used only when `ARB_HOLD_TIMEOUT_EN` is defined.
- `IDX_W`, `$clog2(N_REQ)`: derived width of `grant_idx`; not to be overridden.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `request`  in  N_REQ  per-port request, level-sensitive.
- `grant`  out  N_REQ  registered grant; one-hot or all-zero.
- `grant_idx`  out  IDX_W  binary index of the granted port; holds its last value when idle.
- `busy`  out  1  high when any grant bit is set.
- `preempt`  out  1  one-cycle pulse when a grant was revoked by timeout.

## Operation
- State machine `IDLE` / `OWNED`, plus a registered owner index `own` and a last-winner pointer `last`.
- **Reset:**
  - `grant` = 0, `grant_idx` = 0, `busy` = 0, `preempt` = 0.
  - State is `IDLE`, `last` = N_REQ−1, hold counter = 0.
- **`IDLE`:**
  - If `request` is nonzero, arbitrate and go to `OWNED`; otherwise stay in `IDLE`.
- **`OWNED`, owner still requesting, no timeout:** hold the grant unchanged.
- **`OWNED`, owner drops its request:**
  - Re-arbitrate on the same edge among the current requests.
  - The grant moves directly to the new winner with no idle bubble.
  - If no request is present, go to `IDLE` and set `grant` = 0.
- **Arbitration:**
  - `RR_MODE`=0: the lowest set index wins.
  - `RR_MODE`=1: the search starts at `(last+1) mod N_REQ` and wraps past index N_REQ−1 to 0; the first set bit wins.
  - `last` updates to the winner on every new grant, including a preemption.
- Exactly one grant bit is ever set; `grant_idx` always matches `own` while `busy` = 1.
- **Reset mid-grant:** the grant drops on the next edge regardless of `request`.

## Timing
- Outputs are purely registered; there is no combinational path from `request` to `grant`.
- **Latency:** a request sampled at edge t gives `grant` valid after edge t, visible in cycle t+1.
- **Release:** an owner dropping its request in cycle t loses the grant at edge t, and the next winner is granted at that same edge.
- **Hold counter:**
  - Width is `$clog2(HOLD_MAX+1)`.
  - It clears on every new grant and increments each cycle in `OWNED`, saturating at HOLD_MAX.
- **Simultaneous events:** if the owner drops its request while the timeout fires, it is treated as a normal release and `preempt` stays 0.

## Configuration
- **`ARB_HOLD_TIMEOUT_EN` defined:**
  - When the hold counter equals HOLD_MAX−1, the owner is still requesting, and any other request bit is set, the next edge re-arbitrates with the owner masked out.
  - That edge grants another port and pulses `preempt` for one cycle.
  - If the owner is the sole requester, it keeps the grant; the counter saturates and preemption triggers as soon as a competitor appears.
- **Not defined:**
  - The hold counter and preemption logic are removed.
  - `preempt` is tied to 0 and grants are held indefinitely.
  - `HOLD_MAX` is ignored.

## Test plan
- **Reset and idle:** assert `reset` with `request`=16'hFFFF. Required: `grant`=0, `busy`=0, `preempt`=0 every cycle. Release `reset` → one cycle later `grant`=16'h0001, `grant_idx`=0.
- **Fixed priority (`RR_MODE`=0):**
  - Drive `request`=16'h0A00 → `grant`=16'h0200.
  - Raise bit 1 while bit 9 is held → the grant stays at bit 9.
  - Drop bit 9 → the next cycle gives `grant`=16'h0002.
- **Round-robin rotation (`RR_MODE`=1):**
  - Hold `request`=16'h8011 and let each owner drop for one cycle in turn. Required grant order: bit 0, 4, 15, then wrap to 0.
  - Release with `request`=0 → `IDLE` with `grant`=0.
- **Back-to-back handoff:** the owner at bit 3 drops in the same cycle that bit 7 is requesting. Required: `grant` goes from 16'h0008 to 16'h0080 on a single edge, with `busy` staying 1.
- **Timeout (macro defined, HOLD_MAX=4):**
  - Bit 2 is held with bit 5 also requesting. Required: preemption after 4 grant cycles, `grant`=16'h0020, `preempt` high for 1 cycle.
  - With bit 2 as the sole requester, no preemption occurs.
  - With the macro undefined, there is never any preemption.
- **Reset mid-grant:** assert `reset` while `grant`=16'h0040. Required: `grant`=0 on the next edge; after `reset` is released, round-robin restarts its search from index 0.
